stopwatch_ctrl: RTL and testbench

Controller that sequences the 1 Hz seconds-count datapath on the 100 MHz board clock. Turns three push-buttons into start/pause, clear and lap commands. Gates the tick prescaler and the seconds/minutes counters, and drives the 8 board LEDs. Sits directly between the board pins and the LED output in the top-level display design.

---
 rtl/stopwatch_pkg.sv | 40 ++++
 rtl/btn_debounce.sv | 61 ++++++
 rtl/stopwatch_ctrl.sv | 142 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch controller.
// State/command encodings plus prescaler sizing functions.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_CLEAR,
    CMD_START,
    CMD_LAP
  } cmd_e;

  function automatic int div_of(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int presc_w(input int div);
    return $clog2(div);
  endfunction

  // Clear beats start beats lap; losers are dropped.
  function automatic cmd_e cmd_sel(
    input logic clr,
    input logic start,
    input logic lap
  );
    priority case (1'b1)
      clr:     return CMD_CLEAR;
      start:   return CMD_START;
      lap:     return CMD_LAP;
      default: return CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop sync, optional stable-window
// filter (WINDOW > 0), then a rising-edge pulse.
module btn_debounce #(
  parameter int WINDOW = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, prev_q, lvl;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= lvl;
    end
  end

  if (WINDOW > 0) begin : g_filt
    localparam int CW = $clog2(WINDOW + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic filt_q, filt_d;

    // Level flips only after WINDOW consecutive differing cycles.
    always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (sync2_q != filt_q) begin
        if (cnt_q == CW'(WINDOW - 1)) begin
          filt_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
      end
    end

    assign lvl = filt_q;
  end else begin : g_bypass
    assign lvl = sync2_q;
  end

  assign pulse_o = lvl & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: buttons -> run/pause/clear/lap, 1 Hz count.
// Define STOPWATCH_DEBOUNCE_EN to filter the buttons.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 1,
  parameter int SEC_MAX    = 59,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       BTN_START,
  input  logic       BTN_CLEAR,
  input  logic       BTN_LAP,
  output logic [7:0] LED,
  output logic [7:0] MIN,
  output logic       TICK
);

  localparam int DIV = div_of(CLK_HZ, TICK_HZ);
  localparam int PW  = presc_w(DIV);

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam bit FiltEn = 1'b1;
`else
  localparam bit FiltEn = 1'b0;
`endif
  localparam int DebWin = FiltEn ? DEB_CYCLES : 0;

  logic p_start, p_clear, p_lap;

  btn_debounce #(.WINDOW(DebWin)) u_start (
    .clk_i  (CLK100MHZ),
    .rst_ni (CPU_RESETN),
    .btn_i  (BTN_START),
    .pulse_o(p_start)
  );

  btn_debounce #(.WINDOW(DebWin)) u_clear (
    .clk_i  (CLK100MHZ),
    .rst_ni (CPU_RESETN),
    .btn_i  (BTN_CLEAR),
    .pulse_o(p_clear)
  );

  btn_debounce #(.WINDOW(DebWin)) u_lap (
    .clk_i  (CLK100MHZ),
    .rst_ni (CPU_RESETN),
    .btn_i  (BTN_LAP),
    .pulse_o(p_lap)
  );

  cmd_e cmd;
  assign cmd = cmd_sel(p_clear, p_start, p_lap);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d, lsec_q, lsec_d;
  logic [7:0]    min_q, min_d, lmin_q, lmin_d;
  logic          lap_q, lap_d, tick;
  logic [7:0]    led_q, dmin_q;
  logic          tick_q;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    lap_d   = lap_q;
    lsec_d  = lsec_q;
    lmin_d  = lmin_q;
    tick    = 1'b0;
    unique case (cmd)
      CMD_CLEAR: begin
        state_d = IDLE;
        presc_d = '0;
        sec_d   = '0;
        min_d   = '0;
        lap_d   = 1'b0;
      end
      CMD_START: state_d = (state_q == RUN) ? PAUSE : RUN;
      CMD_LAP: begin
        if (lap_q) begin
          lap_d = 1'b0;
        end else if (state_q == RUN) begin
          lap_d  = 1'b1;
          lsec_d = sec_q;
          lmin_d = min_q;
        end
      end
      default: ;
    endcase
    // Counting follows the current state, so a pause keeps the partial second.
    if (cmd != CMD_CLEAR && state_q == RUN) begin
      if (presc_q == PW'(DIV - 1)) begin
        presc_d = '0;
        tick    = 1'b1;
        if (sec_q == 6'(SEC_MAX)) begin
          sec_d = '0;
          min_d = min_q + 8'd1;
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= IDLE;
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      lap_q   <= 1'b0;
      lsec_q  <= '0;
      lmin_q  <= '0;
      led_q   <= '0;
      dmin_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      lap_q   <= lap_d;
      lsec_q  <= lsec_d;
      lmin_q  <= lmin_d;
      led_q   <= {state_q == RUN, lap_q,
                  lap_q ? lsec_q : sec_q};
      dmin_q  <= lap_q ? lmin_q : min_q;
      tick_q  <= tick;
    end
  end

  assign LED  = led_q;
  assign MIN  = dmin_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed plan items plus random
// button traffic against a seconds-count reference model.
module tb_stopwatch_ctrl;

  localparam int DIV  = 10;
  localparam int SMAX = 59;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       b_start = 1'b0, b_clear = 1'b0, b_lap = 1'b0;
  logic [7:0] led, mn;
  logic       tick;
  logic       b2_start = 1'b0;
  logic [7:0] led2, mn2;
  logic       tick2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stopwatch_ctrl #(
    .CLK_HZ(10), .TICK_HZ(1), .SEC_MAX(SMAX), .DEB_CYCLES(4)
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .BTN_START (b_start),
    .BTN_CLEAR (b_clear),
    .BTN_LAP   (b_lap),
    .LED       (led),
    .MIN       (mn),
    .TICK      (tick)
  );

  // Tiny configuration so the minutes wrap is reachable quickly.
  stopwatch_ctrl #(
    .CLK_HZ(2), .TICK_HZ(1), .SEC_MAX(1), .DEB_CYCLES(4)
  ) dut2 (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .BTN_START (b2_start),
    .BTN_CLEAR (1'b0),
    .BTN_LAP   (1'b0),
    .LED       (led2),
    .MIN       (mn2),
    .TICK      (tick2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  // Reference: elapsed whole seconds, cycles spent running, lap snapshot.
  bit [2:0]   hs, hc, hl;
  int         st, pc, tot, snap;
  bit         lp;
  logic [7:0] e_led = '0, e_min = '0;
  logic       e_tick = 1'b0;
  bit         mon_en = 1'b0;

  task automatic model_reset();
    hs = '0; hc = '0; hl = '0;
    st = 0; pc = 0; tot = 0; snap = 0; lp = 1'b0;
    e_led = '0; e_min = '0; e_tick = 1'b0;
  endtask

  task automatic model_step();
    bit cs, cc, cl, run;
    int sv;
    // A command acts on the 3rd edge after the pin rises.
    cs = hs[1] & ~hs[2];
    cc = hc[1] & ~hc[2];
    cl = hl[1] & ~hl[2];
    hs = {hs[1:0], b_start};
    hc = {hc[1:0], b_clear};
    hl = {hl[1:0], b_lap};
    sv = lp ? snap : tot;
    e_led  = {(st == 1), lp, 6'(sv % (SMAX + 1))};
    e_min  = 8'(sv / (SMAX + 1));
    e_tick = 1'b0;
    if (cc) begin
      st = 0; pc = 0; tot = 0; lp = 1'b0;
    end else begin
      run = (st == 1);
      if (cs) st = run ? 2 : 1;
      else if (cl) begin
        if (lp) lp = 1'b0;
        else if (run) begin lp = 1'b1; snap = tot; end
      end
      if (run) begin
        pc++;
        if (pc == DIV) begin
          pc = 0;
          e_tick = 1'b1;
          tot = (tot + 1) % ((SMAX + 1) * 256);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("m_led", led, e_led);
      chk("m_min", mn, e_min);
      chk("m_tick", tick, e_tick);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit s, input bit c, input bit l,
                       input int hold);
    b_start = s; b_clear = c; b_lap = l;
    repeat (hold) @(negedge clk);
    b_start = 1'b0; b_clear = 1'b0; b_lap = 1'b0;
  endtask

  task automatic wait_tick(input int n, output int t);
    int seen = 0;
    int budget = n * DIV * 3 + 50;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (tick) seen++;
    end
    if (seen < n) chk("tick_timeout", seen, n);
    t = cyc;
  endtask

  int t0, t1, t2, cnt, bud;

  initial begin
    rst_n = 1'b0;
    cycles(3);
    chk("rst_led", led, 8'h00);
    chk("rst_min", mn, 8'h00);
    chk("rst_tick", tick, 0);
    rst_n = 1'b1;
    cycles(1);
`ifdef STOPWATCH_DEBOUNCE_EN
    press(1, 0, 0, 2);
    cycles(20);
    chk("glitch_run", led[7], 0);
    t0 = cyc;
    b_start = 1'b1;
    bud = 40;
    while (!led[7] && bud > 0) begin
      @(negedge clk);
      bud--;
      if (cyc - t0 == 6) b_start = 1'b0;
    end
    // RUN entered 7 edges after the pin, LED one edge later.
    chk("deb_latency", cyc - t0, 8);
    b_start = 1'b0;
    cycles(20);
    chk("deb_still_run", led[7], 1);
`else
    mon_en = 1'b1;
    t0 = cyc;
    press(1, 0, 0, 2);
    wait_tick(1, t1);
    chk("first_tick", t1 - t0, 3 + DIV);
    cycles(1);
    chk("led_1tick", led, 8'h81);
    wait_tick(1, t2);
    chk("tick_period", t2 - t1, DIV);
    wait_tick(3, t1);
    cycles(1);
    chk("led_5tick", led, 8'h85);

    wait_tick(60, t1);
    cycles(1);
    chk("wrap_sec", led[5:0], 5);
    chk("wrap_min", mn, 8'h01);

    // One edge after a tick the prescaler is 1; 3 more give 4.
    press(1, 0, 0, 2);
    cycles(100);
    chk("pause_led7", led[7], 0);
    t0 = cyc;
    press(1, 0, 0, 2);
    wait_tick(1, t1);
    chk("resume_tick", t1 - t0, 3 + 6);

    press(0, 1, 0, 1);
    cycles(4);
    press(1, 0, 0, 2);
    wait_tick(7, t1);
    press(0, 0, 1, 2);
    wait_tick(3, t1);
    cycles(1);
    chk("lap_hold", led, 8'hC7);
    chk("lap_min", mn, 8'h00);
    press(0, 0, 1, 1);
    cycles(4);
    chk("lap_release", led, 8'h8A);

    press(0, 1, 0, 1);
    cycles(4);
    press(1, 0, 0, 2);
    wait_tick(20, t1);
    press(1, 1, 0, 2);
    cycles(4);
    chk("clr_led", led, 8'h00);
    chk("clr_min", mn, 8'h00);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (tick) cnt++;
    end
    chk("clr_no_tick", cnt, 0);

    b2_start = 1'b1;
    cycles(2);
    b2_start = 1'b0;
    cnt = 0;
    bud = 2000;
    while (cnt < 511 && bud > 0) begin
      @(negedge clk);
      bud--;
      if (tick2) cnt++;
    end
    cycles(1);
    chk("min255", mn2, 255);
    chk("min255_led", led2, 8'h81);
    bud = 10;
    while (cnt < 512 && bud > 0) begin
      @(negedge clk);
      bud--;
      if (tick2) cnt++;
    end
    cycles(1);
    chk("min_wrap", mn2, 0);
    chk("min_wrap_led", led2, 8'h80);

    repeat (4000) begin
      @(negedge clk);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        b_start = 1'b0; b_clear = 1'b0; b_lap = 1'b0;
        #1;
        chk("async_rst_led", led, 8'h00);
        chk("async_rst_tick", tick, 0);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        b_start = b_start ^ ($urandom_range(0, 99) < 4);
        b_lap   = b_lap ^ ($urandom_range(0, 99) < 4);
        b_clear = b_clear ^ ($urandom_range(0, 999) < 8);
      end
    end
    mon_en = 1'b0;
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
